snn_infer_ctrl: RTL
===================

SNN_INFER_CTRL -- requirements
Module: snn_infer_ctrl

Interface
REQ-001 SHALL have parameter WINDOW_LEN, default 16: number of RUN timesteps per inference; legal range 1..255.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 2: cycles of network clear before RUN; legal range 1..15.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 2: cycles after RUN for hidden-to-output-to-counter spikes to settle; legal range 0..15.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start_i, input, 1: request one inference; sampled only in IDLE.
REQ-007 SHALL have port abort_i, input, 1: cancel the inference in progress.
REQ-008 SHALL have port pixels_i, input, 8: input spike pattern; latched when start is accepted.
REQ-009 SHALL have port pred_digit_i, input, 4: predicted digit from the max-spike readout.
REQ-010 SHALL have port net_pixels_o, output, 8: spike inputs driven into the hidden layer.
REQ-011 SHALL have port net_clear_o, output, 1: clears LIF membranes, thresholds and spike counters.
REQ-012 SHALL have port net_en_o, output, 1: network timestep enable.
REQ-013 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-014 SHALL have port step_o, output, 8: current RUN timestep index.
REQ-015 SHALL have port result_o, output, 4: captured digit.
REQ-016 SHALL have port result_valid_o, output, 1: result_o holds a completed inference.
REQ-017 SHALL have port done_o, output, 1: one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN, CAPTURE; net_* and busy_o SHALL be decoded from registered state only (Moore).
REQ-019 IDLE: when start_i=1 and abort_i=0, SHALL latch pixels_i into pix_q, clear result_valid_o and go to CLEAR; otherwise SHALL stay in IDLE.
REQ-020 CLEAR: net_clear_o=1, net_en_o=0, net_pixels_o=0, for exactly CLEAR_CYCLES cycles, then go to RUN.
REQ-021 RUN: net_en_o=1, net_pixels_o=pix_q, net_clear_o=0; step_o SHALL count 0..WINDOW_LEN-1, one per cycle; after the cycle with step_o=WINDOW_LEN-1, go to DRAIN.
REQ-022 DRAIN: net_en_o=1, net_pixels_o=0, for DRAIN_CYCLES cycles; if DRAIN_CYCLES=0, RUN SHALL go directly to CAPTURE.
REQ-023 CAPTURE: one cycle with net_en_o=0; at its closing edge, result_o<=pred_digit_i, result_valid_o<=1, done_o<=1, state<=IDLE.
REQ-024 done_o SHALL be high for exactly one cycle, the first IDLE cycle after CAPTURE.
REQ-025 step_o SHALL be 0 outside RUN; the internal phase counters SHALL be sized for the 255/15 maxima and SHALL never wrap.
REQ-026 start_i outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-027 start_i in the done_o cycle SHALL be accepted (back-to-back); result_valid_o falls at that edge and result_o holds its old value until the next CAPTURE.
REQ-028 abort_i=1 in CLEAR/RUN/DRAIN/CAPTURE SHALL force IDLE at the next edge, with result_o unchanged, result_valid_o=0 and no done_o pulse.
REQ-029 abort_i and start_i both high in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-030 Latency SHALL be start-sample edge to done_o cycle = CLEAR_CYCLES+WINDOW_LEN+DRAIN_CYCLES+2 cycles.

Reset
REQ-031 rst_i=1 at an edge SHALL force IDLE, with pix_q=0, step_o=0, result_o=0, result_valid_o=0, done_o=0, busy_o=0, net_en_o=0, net_clear_o=0 and net_pixels_o=0, from any state including mid-RUN.
REQ-032 rst_i SHALL have priority over start_i and abort_i.

Verification
REQ-033 Defaults; pixels_i=8'hA5, start_i pulsed at edge 0, pred_digit_i=7 -> busy_o high in cycles 1..21, net_clear_o in cycles 1..2, net_pixels_o=8'hA5 in cycles 3..18 (step_o 0..15), done_o=1, result_o=7 and result_valid_o=1 in cycle 22.
REQ-034 abort_i=1 at step_o=5 -> IDLE next cycle, net_en_o=0, no done_o, result_valid_o=0, result_o keeps its prior value.
REQ-035 start_i held high continuously with defaults -> inferences complete every 22 cycles; start_i during busy_o has no effect.
REQ-036 rst_i=1 mid-RUN with result_valid_o=1 from a prior run -> all outputs at reset values next cycle; a following start runs the full 21-cycle sequence.
REQ-037 WINDOW_LEN=1, DRAIN_CYCLES=0 -> RUN lasts one cycle with step_o=0, CAPTURE follows immediately, done_o 5 cycles after the start-sample edge.
REQ-038 start_i=1 and abort_i=1 together in IDLE -> busy_o stays 0 and pix_q is not updated.

Source files
------------

// File: rtl/snn_infer_ctrl.sv
// snn_infer_ctrl: sequences one spiking-network inference.
// Phases: clear the network, stream the latched pixel spikes for a fixed
// window, let in-flight spikes drain to the counters, then capture the
// max-spike digit. Network controls are decoded from the registered state only.
module snn_infer_ctrl #(
  parameter int WINDOW_LEN   = 16,  // 1..255
  parameter int CLEAR_CYCLES = 2,   // 1..15
  parameter int DRAIN_CYCLES = 2    // 0..15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] pixels_i,
  input  logic [3:0] pred_digit_i,
  output logic [7:0] net_pixels_o,
  output logic       net_clear_o,
  output logic       net_en_o,
  output logic       busy_o,
  output logic [7:0] step_o,
  output logic [3:0] result_o,
  output logic       result_valid_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_CAPTURE
  } state_t;

  // Last count value of each phase; the counter stops there, so it never wraps.
  localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0] WIN_LAST = 8'(WINDOW_LEN - 1);
  localparam logic [7:0] DRN_LAST = 8'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pix_q;
  logic       accept;
  logic       cancel;

  // Next-state and phase-counter logic; abort overrides any in-flight phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cancel  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          accept  = 1'b1;
          state_d = S_CLEAR;
          cnt_d   = 8'd0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = S_RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (cnt_q == WIN_LAST) begin
          state_d = (DRAIN_CYCLES == 0) ? S_CAPTURE : S_DRAIN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRN_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    if (abort_i && state_q != S_IDLE) begin
      cancel  = 1'b1;
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end
  end

  // State, pixel latch and result registers; reset dominates start/abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      pix_q          <= 8'd0;
      result_o       <= 4'd0;
      result_valid_o <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_o  <= 1'b0;
      if (accept) begin
        pix_q          <= pixels_i;
        result_valid_o <= 1'b0;
      end
      if (cancel) begin
        result_valid_o <= 1'b0;
      end else if (state_q == S_CAPTURE) begin
        result_o       <= pred_digit_i;
        result_valid_o <= 1'b1;
        done_o         <= 1'b1;
      end
    end
  end

  // Moore decode of network controls from the registered state.
  always_comb begin
    net_pixels_o = 8'd0;
    net_clear_o  = 1'b0;
    net_en_o     = 1'b0;
    step_o       = 8'd0;
    busy_o       = (state_q != S_IDLE);
    case (state_q)
      S_CLEAR: net_clear_o = 1'b1;
      S_RUN: begin
        net_en_o     = 1'b1;
        net_pixels_o = pix_q;
        step_o       = cnt_q;
      end
      S_DRAIN: net_en_o = 1'b1;
      default: ;
    endcase
  end

endmodule
